// File: rtl/aidc_lite_job_seq_if.sv
// APB bus between the job sequencer and the two AIDC Lite engines.
// One shared bus with a select line per engine; prdata/pready/pslverr are muxed outside.
interface aidc_lite_job_seq_if #(
  parameter int ADDR_W = 32
);
  logic              psel0;
  logic              psel1;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel0, psel1, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel0, psel1, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/aidc_lite_job_seq.sv
// Compress-then-decompress job sequencer driving both AIDC Lite engines over APB.
// Optional macro AIDC_SEQ_TIMEOUT_EN adds a per-stage status-poll limit (MAX_POLLS).
//
// state  | meaning
// S_IDLE | waiting for job_start
// S_CFG  | four register writes (src, dst, len, ctrl) to the current engine
// S_POLL | one status read of the current engine
// S_GAP  | idle down-count between status reads
// S_NEXT | chain from compression to decompression, or finish
// S_FIN  | pulse done, drop busy
module aidc_lite_job_seq #(
  parameter int POLL_GAP  = 100,
  parameter int MAX_POLLS = 10000,
  parameter int ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                job_start,
  input  logic [ADDR_W-1:0]   job_src,
  input  logic [ADDR_W-1:0]   job_tmp,
  input  logic [ADDR_W-1:0]   job_dst,
  input  logic [31:0]         job_clen,
  input  logic [31:0]         job_dlen,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic                stage,
  aidc_lite_job_seq_if.master apb
);
  localparam int GAP_LD = (POLL_GAP < 1) ? 1 : POLL_GAP;
  localparam int GAP_W  = $clog2(GAP_LD) + 1;
  localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(GAP_LD - 1);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h10);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_POLL, S_GAP, S_NEXT, S_FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q, tmp_q, dst_q;
  logic [31:0]       clen_q, dlen_q;
  logic [1:0]        wr_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic              psel0_q, psel1_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;
  logic [ADDR_W-1:0] cfg_addr;
  logic [31:0]       cfg_data;
  logic              xfer_active;

`ifdef AIDC_SEQ_TIMEOUT_EN
  localparam int PC_W = $clog2(MAX_POLLS) + 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(MAX_POLLS - 1);
  logic [PC_W-1:0] poll_cnt;
`else
  logic unused_max_polls;
  assign unused_max_polls = (MAX_POLLS > 0);
`endif

  assign apb.psel0   = psel0_q;
  assign apb.psel1   = psel1_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  assign xfer_active = psel0_q | psel1_q;

  // Decompression reads from where compression wrote, hence tmp in both stages.
  always_comb begin
    cfg_addr = ADDR_W'({wr_idx, 2'b00});
    cfg_data = 32'd1;
    case (wr_idx)
      2'd0:    cfg_data = stage ? 32'(tmp_q) : 32'(src_q);
      2'd1:    cfg_data = stage ? 32'(dst_q) : 32'(tmp_q);
      2'd2:    cfg_data = stage ? dlen_q : clen_q;
      default: cfg_data = 32'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      stage     <= 1'b0;
      src_q     <= '0;
      tmp_q     <= '0;
      dst_q     <= '0;
      clen_q    <= '0;
      dlen_q    <= '0;
      wr_idx    <= 2'd0;
      gap_cnt   <= '0;
      psel0_q   <= 1'b0;
      psel1_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
`ifdef AIDC_SEQ_TIMEOUT_EN
      poll_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (job_start) begin
            src_q    <= job_src;
            tmp_q    <= job_tmp;
            dst_q    <= job_dst;
            clen_q   <= job_clen;
            dlen_q   <= job_dlen;
            busy     <= 1'b1;
            stage    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            wr_idx   <= 2'd0;
`ifdef AIDC_SEQ_TIMEOUT_EN
            poll_cnt <= '0;
`endif
            state    <= S_CFG;
          end
        end
        S_CFG: begin
          // Bus is idle at least one cycle after each completion before the next setup.
          if (!xfer_active) begin
            psel0_q  <= ~stage;
            psel1_q  <= stage;
            pwrite_q <= 1'b1;
            paddr_q  <= cfg_addr;
            pwdata_q <= cfg_data;
          end else if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (apb.pready) begin
            psel0_q   <= 1'b0;
            psel1_q   <= 1'b0;
            penable_q <= 1'b0;
            if (apb.pslverr) begin
              err      <= 1'b1;
              err_code <= 2'd1;
              state    <= S_FIN;
            end else if (wr_idx == 2'd3) begin
              wr_idx <= 2'd0;
              state  <= S_POLL;
            end else begin
              wr_idx <= wr_idx + 2'd1;
            end
          end
        end
        S_POLL: begin
          if (!xfer_active) begin
            psel0_q  <= ~stage;
            psel1_q  <= stage;
            pwrite_q <= 1'b0;
            paddr_q  <= A_STATUS;
            pwdata_q <= '0;
          end else if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (apb.pready) begin
            psel0_q   <= 1'b0;
            psel1_q   <= 1'b0;
            penable_q <= 1'b0;
            if (apb.pslverr) begin
              err      <= 1'b1;
              err_code <= 2'd1;
              state    <= S_FIN;
            end else if (apb.prdata == 32'd1) begin
              state <= S_NEXT;
`ifdef AIDC_SEQ_TIMEOUT_EN
            end else if (poll_cnt == PC_LAST) begin
              poll_cnt <= poll_cnt + PC_W'(1);
              err      <= 1'b1;
              err_code <= 2'd2;
              state    <= S_FIN;
`endif
            end else begin
`ifdef AIDC_SEQ_TIMEOUT_EN
              poll_cnt <= poll_cnt + PC_W'(1);
`endif
              gap_cnt <= GAP_INIT;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_POLL;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        S_NEXT: begin
          if (!stage) begin
            stage  <= 1'b1;
            wr_idx <= 2'd0;
`ifdef AIDC_SEQ_TIMEOUT_EN
            poll_cnt <= '0;
`endif
            state  <= S_CFG;
          end else begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aidc_lite_job_seq.sv
// Randomized bench for aidc_lite_job_seq: an APB slave model records every transfer and
// checks bus protocol; a job-level model predicts the transfer list and final status.
module tb_aidc_lite_job_seq;
  localparam int POLL_GAP  = 5;
  localparam int MAX_POLLS = 4;
`ifdef AIDC_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        job_start = 1'b0;
  logic [31:0] job_src = '0, job_tmp = '0, job_dst = '0, job_clen = '0, job_dlen = '0;
  logic        busy, done, err, stage;
  logic [1:0]  err_code;

  aidc_lite_job_seq_if #(.ADDR_W(32)) apb ();

  aidc_lite_job_seq #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start),
    .job_src(job_src), .job_tmp(job_tmp), .job_dst(job_dst),
    .job_clen(job_clen), .job_dlen(job_dlen),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .stage(stage),
    .apb(apb)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- APB slave model ----------------
  xact_t obs_q[$];
  xact_t cur;
  int job_id = 0, seen_job = 0, cfg_ws = 0, cfg_err_at = -1;
  int cfg_np[2];
  int cyc = 0, x_idx = 0, wait_left = 0, rd_total = 0;
  int rd_cnt[2];
  int last_rd_cyc[2];
  int bad_sel = 0, bad_stable = 0, bad_b2b = 0, bad_gap = 0;
  logic prev_sel = 1'b0;
  int done_cnt = 0;

  always @(negedge clk) begin : apb_slave
    logic any_sel;
    cyc++;
    if (job_id != seen_job) begin
      seen_job = job_id;
      rd_cnt[0] = 0; rd_cnt[1] = 0;
      last_rd_cyc[0] = -1000; last_rd_cyc[1] = -1000;
      x_idx = 0;
    end
    any_sel = apb.psel0 | apb.psel1;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = 32'h0;
    if (apb.psel0 && apb.psel1) bad_sel++;
    if (any_sel && (apb.psel1 != stage)) bad_sel++;
    if (!any_sel && apb.penable) bad_sel++;
    if (any_sel && !apb.penable) begin
      if (prev_sel) bad_b2b++;
      cur.sel  = apb.psel1;
      cur.wr   = apb.pwrite;
      cur.addr = apb.paddr;
      cur.data = apb.pwrite ? apb.pwdata : 32'h0;
      wait_left = (cfg_ws < 0) ? int'($urandom_range(0, 3)) : cfg_ws;
      if (!apb.pwrite) begin
        if (cyc - last_rd_cyc[apb.psel1] < POLL_GAP + 2) bad_gap++;
        last_rd_cyc[apb.psel1] = cyc;
      end
    end else if (any_sel) begin
      if ({apb.psel1, apb.pwrite, apb.paddr, (apb.pwrite ? apb.pwdata : 32'h0)} != cur) bad_stable++;
      if (wait_left > 0) begin
        wait_left--;
      end else begin
        apb.pready  = 1'b1;
        apb.pslverr = (x_idx == cfg_err_at);
        if (!apb.pwrite) begin
          rd_cnt[apb.psel1]++;
          rd_total++;
          if (cfg_np[apb.psel1] > 0 && rd_cnt[apb.psel1] >= cfg_np[apb.psel1]) apb.prdata = 32'h1;
          else apb.prdata = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h0;
        end
        obs_q.push_back(cur);
        x_idx++;
      end
    end
    prev_sel = any_sel;
  end

  always @(negedge clk) if (done) done_cnt++;

  // ---------------- job-level reference model ----------------
  xact_t exp_q[$];

  function automatic xact_t mk(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
    xact_t x;
    x.sel = (s != 0); x.wr = w; x.addr = a; x.data = d;
    return x;
  endfunction

  task automatic build_exp(input logic [31:0] src, tmp, dst, clen, dlen,
                           input int np0, np1, err_at,
                           output logic e_err, output logic [1:0] e_code, output logic e_stage);
    logic [31:0] wd[4];
    int idx, np;
    bit stop, hit;
    idx = 0; stop = 0;
    exp_q.delete();
    e_err = 0; e_code = 0; e_stage = 0;
    for (int s = 0; s < 2 && !stop; s++) begin
      e_stage = (s != 0);
      if (s == 0) begin wd[0] = src; wd[1] = tmp; wd[2] = clen; end
      else        begin wd[0] = tmp; wd[1] = dst; wd[2] = dlen; end
      wd[3] = 32'h1;
      np = (s == 0) ? np0 : np1;
      for (int i = 0; i < 4 && !stop; i++) begin
        exp_q.push_back(mk(s, 1'b1, 32'(i * 4), wd[i]));
        hit = (idx == err_at); idx++;
        if (hit) begin e_err = 1; e_code = 2'd1; stop = 1; end
      end
      for (int p = 1; !stop && p <= 1000; p++) begin
        exp_q.push_back(mk(s, 1'b0, 32'h10, 32'h0));
        hit = (idx == err_at); idx++;
        if (hit) begin e_err = 1; e_code = 2'd1; stop = 1; end
        else if (np > 0 && p >= np) break;
        else if (TIMEOUT_EN && p == MAX_POLLS) begin e_err = 1; e_code = 2'd2; stop = 1; end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic pulse_start(input logic [31:0] src, tmp, dst, clen, dlen);
    @(negedge clk);
    job_src = src; job_tmp = tmp; job_dst = dst; job_clen = clen; job_dlen = dlen;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic run_job(input string name, input logic [31:0] src, tmp, dst, clen, dlen,
                         input int np0, np1, err_at, ws);
    logic e_err, e_stage, pb;
    logic [1:0] e_code;
    int base, dbase;
    bit got;
    build_exp(src, tmp, dst, clen, dlen, np0, np1, err_at, e_err, e_code, e_stage);
    cfg_np[0] = np0; cfg_np[1] = np1; cfg_err_at = err_at; cfg_ws = ws;
    job_id++;
    base = obs_q.size(); dbase = done_cnt;
    pulse_start(src, tmp, dst, clen, dlen);
    chk({name, ":start_state"}, {busy, err, err_code, stage}, {1'b1, 1'b0, 2'd0, 1'b0});
    got = 0; pb = busy;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
      else pb = busy;
      // A start request mid-job must be ignored.
      if (c == 12 && busy && !done) begin
        job_src = $urandom; job_tmp = $urandom; job_dst = $urandom;
        job_clen = $urandom; job_dlen = $urandom; job_start = 1'b1;
      end else begin
        job_start = 1'b0;
      end
    end
    job_start = 1'b0;
    chk({name, ":done_seen"}, got, 1'b1);
    chk({name, ":busy_before_done"}, pb, 1'b1);
    chk({name, ":end_state"}, {busy, err, err_code, stage}, {1'b0, e_err, e_code, e_stage});
    chk({name, ":n_xact"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s:xact%0d", name, i), (base + i < obs_q.size()) ? obs_q[base + i] : '0, exp_q[i]);
    @(negedge clk);
    chk({name, ":done_width"}, done, 1'b0);
    chk({name, ":done_count"}, done_cnt - dbase, 1);
    chk({name, ":apb_sel"}, bad_sel, 0);
    chk({name, ":apb_stable"}, bad_stable, 0);
    chk({name, ":apb_b2b"}, bad_b2b, 0);
    chk({name, ":poll_gap"}, bad_gap, 0);
  endtask

  function automatic logic [95:0] out_vec();
    return {busy, done, err, err_code, stage, apb.psel0, apb.psel1, apb.penable, apb.pwrite,
            apb.paddr, apb.pwdata};
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int np0, np1, ea, base_rd, dc;
    bit reached;
    cfg_np[0] = 1; cfg_np[1] = 1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", out_vec(), '0);

    run_job("nominal",  32'h0, 32'h20000, 32'h30000, 32'h100, 32'h80, 3, 2, -1, 0);
    run_job("waitst",   32'h0, 32'h20000, 32'h30000, 32'h100, 32'h80, 3, 2, -1, 3);
    run_job("slverr",   32'h0, 32'h20000, 32'h30000, 32'h100, 32'h80, 3, 2, 9, 0);
    run_job("restart",  32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h40, 32'h44, 1, 1, -1, 1);

    for (int k = 0; k < 6; k++) begin
      np0 = int'($urandom_range(1, 4));
      np1 = int'($urandom_range(1, 4));
      ea  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7 + np0 + np1)) : -1;
      run_job($sformatf("rand%0d", k), $urandom, $urandom, $urandom, $urandom, $urandom,
              np0, np1, ea, -1);
    end

    // Reset in the middle of a stage-0 status read.
    cfg_np[0] = 0; cfg_np[1] = 0; cfg_err_at = -1; cfg_ws = 1;
    job_id++;
    base_rd = rd_total;
    pulse_start($urandom, $urandom, $urandom, $urandom, $urandom);
    reached = 0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(negedge clk);
      if (rd_total > base_rd && apb.psel0 && !apb.penable) reached = 1;
    end
    chk("rstmid:reached_poll", reached, 1'b1);
    dc = done_cnt;
    #2 rst_n = 1'b0;
    #1 chk("rstmid:async_clear", out_vec(), '0);
    repeat (4) @(negedge clk);
    chk("rstmid:held", out_vec(), '0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rstmid:no_done", done_cnt - dc, 0);
    chk("rstmid:idle", {busy, apb.psel0, apb.psel1}, 3'b000);

`ifdef AIDC_SEQ_TIMEOUT_EN
    run_job("timeout", $urandom, $urandom, $urandom, $urandom, $urandom, 0, 1, -1, -1);
`else
    cfg_np[0] = 0; cfg_np[1] = 0; cfg_err_at = -1; cfg_ws = 0;
    job_id++;
    base_rd = rd_total; dc = done_cnt;
    pulse_start($urandom, $urandom, $urandom, $urandom, $urandom);
    repeat (150) @(negedge clk);
    chk("notmo:no_done", done_cnt - dc, 0);
    chk("notmo:reads_past_max", (rd_total - base_rd) > MAX_POLLS, 1'b1);
    chk("notmo:still_busy", busy, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/aidc_lite_job_seq.md
Name: aidc_lite_job_seq

Overview:
- Hardware sequencer that runs one compress-then-decompress job over the two AIDC Lite engines without CPU involvement.
- Acts as a single APB master; two select lines address the compression engine (psel0) and the decompression engine (psel1).
- Programs each engine's register file, starts it, polls its status register, then chains to the next stage.
- Sits between the system control logic and the APB ports of the AIDC_LITE_COMP_TOP and AIDC_LITE_DECOMP_TOP instances.

Parameters:
- POLL_GAP, 100: idle clk cycles between consecutive status reads.
- MAX_POLLS, 10000: status reads per stage before a timeout is declared (used only with the optional feature).
- ADDR_W, 32: APB address and job address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_start  in  1  one-cycle pulse; accepted only while idle
- job_src  in  32  compression source address
- job_tmp  in  32  compression destination; also the decompression source
- job_dst  in  32  decompression destination
- job_clen  in  32  compression length in bytes
- job_dlen  in  32  decompression length in bytes
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when a job ends, successful or not
- err  out  1  sticky error flag; cleared by the next accepted job_start
- err_code  out  2  0 none, 1 pslverr, 2 timeout
- stage  out  1  0 compression, 1 decompression
- psel0  out  1  APB select, compression engine
- psel1  out  1  APB select, decompression engine
- penable  out  1  APB enable
- pwrite  out  1  APB write
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data, muxed from the selected engine
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset values: every output is 0. The FSM is in IDLE and all counters are cleared.
- Engine register map (same for both engines):
  - 0x0 source address
  - 0x4 destination address
  - 0x8 length
  - 0xC control; writing 1 starts the engine
  - 0x10 status; reading 1 means done
- FSM states: IDLE, CFG, POLL, GAP, NEXT, FIN.
- IDLE:
  - On job_start, latch all job_* inputs, set busy=1, stage=0, clear err and err_code, go to CFG.
  - job_start is ignored while busy.
- CFG: issues four APB writes in order, one at a time.
  - Stage 0: 0x0=src, 0x4=tmp, 0x8=clen, 0xC=1.
  - Stage 1: 0x0=tmp, 0x4=dst, 0x8=dlen, 0xC=1.
- APB transfer timing:
  - Setup cycle: psel=1, penable=0.
  - Access cycles: penable=1, held until pready=1.
  - paddr, pwdata, pwrite and psel stay stable from setup to completion.
  - After completion, psel and penable drop for at least one cycle; back-to-back transfers are not permitted.
  - Only the select line for the current stage is ever asserted.
- POLL: issues one APB read of 0x10.
  - prdata==1 at completion: go to NEXT.
  - Otherwise: go to GAP.
- GAP: wait POLL_GAP cycles, then return to POLL. A POLL_GAP of 0 behaves as 1.
- NEXT:
  - From stage 0: set stage=1, go to CFG.
  - From stage 1: go to FIN.
- FIN: pulse done=1 for one cycle, drop busy, go to IDLE. stage keeps its last value.
- pslverr error:
  - pslverr=1 at completion of any transfer sets err=1, err_code=1.
  - That transfer finishes normally, then the FSM goes to FIN; no further APB traffic.
- Reset during a job: aborts immediately. Outputs return to reset values and the APB bus is released, even mid-transfer.
- Length fields are passed through unmodified; the block does no arithmetic on them.

Optional Feature:
- Macro: AIDC_SEQ_TIMEOUT_EN.
- Defined:
  - A per-stage poll counter, log2(MAX_POLLS)+1 bits, increments on each status read that returns not-done. It is cleared on entry to CFG.
  - When it reaches MAX_POLLS, set err=1, err_code=2, and go to FIN without issuing another read.
- Not defined:
  - No counter is built and polling continues indefinitely.
  - err_code value 2 is never produced.

Test Plan:
- Nominal job: job_src=0x0, tmp=0x20000, dst=0x30000, clen=0x100, dlen=0x80; comp status goes to 1 on the 3rd poll, decomp on the 2nd.
  - Required: 8 writes in the exact order and with the exact values listed under CFG.
  - Required: 5 reads; polls spaced at least POLL_GAP+2 cycles apart.
  - Required: one done pulse, err=0, busy falls on the same cycle done pulses.
- Wait states: pready held low 3 cycles on every transfer.
  - Required: setup/access protocol holds, signals stable throughout, same final result as the nominal job.
- Slave error: pslverr=1 on the 0x8 write of stage 1.
  - Required: no 0xC write to the decompression engine, done pulses, err=1, err_code=1.
- Busy and restart: job_start while busy is ignored; a second job after done is accepted.
  - Required: the second job clears err and runs with the newly latched addresses.
- Reset mid-job: rst_n=0 during stage 0 polling.
  - Required: all outputs 0 asynchronously, psel0/psel1 low, no done pulse.
- Timeout (AIDC_SEQ_TIMEOUT_EN defined, MAX_POLLS=4): status never reaches 1.
  - Required: exactly 4 reads, then done with err_code=2.
  - Macro undefined: reads continue past 4 and no done pulse occurs.
